// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and constants for the pipeline controller:
//   stall_bus_t   - stall bus, bit0 PC .. bit5 WB (1 = hold stage register)
//   pipe_state_t  - controller FSM states
//   STALL_*       - canonical stall patterns driven onto the stall bus
package pipe_ctrl_pkg;

  localparam int unsigned STALL_BUS_W = 6;

  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_RUN  = 2'd1,
    ST_DIV_DONE = 2'd2
  } pipe_state_t;

  // Nothing held.
  localparam stall_bus_t STALL_NONE    = 6'b000000;
  // Hold PC/IF/ID, bubble goes into EX.
  localparam stall_bus_t STALL_LOADUSE = 6'b000111;
  // Hold PC/IF/ID/EX, bubble goes into MEM.
  localparam stall_bus_t STALL_EXHOLD  = 6'b001111;

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central pipeline controller for the five-stage core. Drives the shared
// stall bus and sequences three events, highest priority first:
// exception flush from MEM, multi-cycle divide in EX, load-use bubble from ID.
//
// Parameters:
//   DIV_CYCLES  - divider iteration cycles after the start pulse (>= 1)
//   STALL_W     - stall bus width
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   stallreq_id  in   load-use hazard detected in ID
//   div_req      in   EX holds a div/divu (high while it stays in EX)
//   excp_req     in   MEM signals an exception
//   excp_pc      in   redirect PC, valid with excp_req
//   stall        out  per-stage hold, bit0 PC .. bit5 WB
//   flush        out  clear IF/ID/EX and redirect PC
//   new_pc       out  redirect target, valid with flush (0 otherwise)
//   div_start    out  one-cycle divider start pulse
//   div_done     out  one-cycle pulse, divider result valid
// All outputs are combinational from the current state and inputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_id,
  input  logic               div_req,
  input  logic               excp_req,
  input  logic [31:0]        excp_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               div_start,
  output logic               div_done
);

  localparam int unsigned CNT_W = (DIV_CYCLES + 1 > 1) ? $clog2(DIV_CYCLES + 1) : 1;

  pipe_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [STALL_W-1:0] stall_c;
  logic               flush_c;
  logic [31:0]        new_pc_c;
  logic               div_start_c;
  logic               div_done_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    stall_c     = '0;
    flush_c     = 1'b0;
    new_pc_c    = '0;
    div_start_c = 1'b0;
    div_done_c  = 1'b0;

    if (excp_req) begin
      // Exception wins in every state and aborts any divide in flight.
      flush_c  = 1'b1;
      new_pc_c = excp_pc;
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (div_req) begin
            stall_c     = STALL_W'(STALL_EXHOLD);
            div_start_c = 1'b1;
            cnt_nx      = CNT_W'(DIV_CYCLES - 1);
            state_nx    = ST_DIV_RUN;
          end else if (stallreq_id) begin
            stall_c = STALL_W'(STALL_LOADUSE);
          end
        end
        ST_DIV_RUN: begin
          // cnt runs DIV_CYCLES-1 down to 0, giving DIV_CYCLES cycles here.
          stall_c = STALL_W'(STALL_EXHOLD);
          if (cnt == '0) begin
            state_nx = ST_DIV_DONE;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        ST_DIV_DONE: begin
          // div_req still belongs to the finishing instruction; no restart.
          div_done_c = 1'b1;
          state_nx   = ST_IDLE;
          if (stallreq_id) begin
            stall_c = STALL_W'(STALL_LOADUSE);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are forced quiet for as long as reset is held.
  always_comb begin
    if (!rst) begin
      stall     = '0;
      flush     = 1'b0;
      new_pc    = '0;
      div_start = 1'b0;
      div_done  = 1'b0;
    end else begin
      stall     = stall_c;
      flush     = flush_c;
      new_pc    = new_pc_c;
      div_start = div_start_c;
      div_done  = div_done_c;
    end
  end

endmodule
